micro_param: RTL and testbench

- Parametrised single-cycle accumulator microcontroller: W register, NREGS-entry register file, zero flag, conditional branches, skip-on-zero, and a hardware call/return stack with fault detection.
- Fetches from an external combinational program ROM: addressed by pc, returns inst the same cycle.
- Debug read port exposes the register file to benches and higher-level lab top-levels.

---
 rtl/micro_param.sv | 230 +++++++++++++++++++++++
 tb/tb_micro_param.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/micro_param.sv
// ---------------------------------------------------------------------------
// micro_param
//
// Parametrised single-cycle accumulator microcontroller. It has a W
// accumulator, an NREGS-entry register file, a zero flag, conditional
// branches, skip-on-zero and a hardware call/return stack. A call on a full
// stack or a return on an empty stack sends the core to FAULT. Instructions
// come from an external combinational ROM that is addressed by pc.
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous reset, active low
//   run       1 = execute one instruction per cycle, 0 = hold all state
//   inst      instruction word read from ROM[pc]
//   pc        program counter / ROM address
//   w         accumulator
//   is_zero   zero flag
//   halted    core is in HALT or FAULT
//   fault     a stack overflow or underflow occurred
//   dbg_sel   register-file debug select
//   dbg_data  R[dbg_sel], combinational
//
// Instruction word: {op[3:0], d, imm[IMM_W-1:0]}
//   k = imm[DATA_W-1:0], a = imm[PC_W-1:0], r = imm[RA_W-1:0]
//   d = 0 writes the result to W, d = 1 writes it to R[r]
// ---------------------------------------------------------------------------
module micro_param #(
    parameter  int DATA_W      = 8,
    parameter  int PC_W        = 8,
    parameter  int NREGS       = 4,
    parameter  int STACK_DEPTH = 4,
    localparam int RA_W        = $clog2(NREGS),
    localparam int IMM_W       = (DATA_W > PC_W) ? DATA_W : PC_W,
    localparam int INST_W      = IMM_W + 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run,
    input  logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   pc,
    output logic [DATA_W-1:0] w,
    output logic              is_zero,
    output logic              halted,
    output logic              fault,
    input  logic [RA_W-1:0]   dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    // sp must be able to hold 0..STACK_DEPTH inclusive.
    localparam int SP_W   = $clog2(STACK_DEPTH + 1);
    localparam int STK_AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_HALT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    typedef enum logic [3:0] {
        OP_NOP    = 4'h0,
        OP_MOVLW  = 4'h1,
        OP_ADDLW  = 4'h2,
        OP_MOVWF  = 4'h3,
        OP_MOVF   = 4'h4,
        OP_ADDWF  = 4'h5,
        OP_SUBWF  = 4'h6,
        OP_ANDWF  = 4'h7,
        OP_XORWF  = 4'h8,
        OP_GOTO   = 4'h9,
        OP_BZ     = 4'hA,
        OP_BNZ    = 4'hB,
        OP_CALL   = 4'hC,
        OP_RETURN = 4'hD,
        OP_DECFSZ = 4'hE,
        OP_HALT   = 4'hF
    } op_t;

    // Architectural state
    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0] w_q, w_d;
    logic              z_q, z_d;
    logic [SP_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0] regs  [NREGS];
    logic [PC_W-1:0]   stack [STACK_DEPTH];

    // Instruction fields
    op_t               op;
    logic              dest_reg;
    logic [DATA_W-1:0] k;
    logic [PC_W-1:0]   a;
    logic [RA_W-1:0]   r;

    assign op       = op_t'(inst[INST_W-1 -: 4]);
    assign dest_reg = inst[IMM_W];
    assign k        = inst[DATA_W-1:0];
    assign a        = inst[PC_W-1:0];
    assign r        = inst[RA_W-1:0];

    // Datapath helpers
    logic [DATA_W-1:0] src;
    logic [PC_W-1:0]   pc_inc;
    logic [STK_AW-1:0] push_idx;
    logic [STK_AW-1:0] pop_idx;

    assign src      = regs[r];
    assign pc_inc   = pc_q + PC_W'(1);
    assign push_idx = STK_AW'(sp_q);
    assign pop_idx  = STK_AW'(sp_q - SP_W'(1));

    // Decode / execute results
    logic [DATA_W-1:0] result;
    logic              write_w;
    logic              write_r;
    logic              upd_z;
    logic              stk_push;

    // NOTE: combinational logic uses blocking assignments, and every output
    // gets a default first, so no path can leave a latch behind.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        w_d      = w_q;
        z_d      = z_q;
        sp_d     = sp_q;
        result   = '0;
        write_w  = 1'b0;
        write_r  = 1'b0;
        upd_z    = 1'b0;
        stk_push = 1'b0;

        if (run && state_q == S_RUN) begin
            pc_d = pc_inc;
            unique case (op)
                OP_NOP: ;
                OP_MOVLW: begin
                    result  = k;
                    write_w = 1'b1;
                    upd_z   = 1'b1;
                end
                OP_ADDLW: begin
                    result  = w_q + k;
                    write_w = 1'b1;
                    upd_z   = 1'b1;
                end
                OP_MOVWF: begin
                    result  = w_q;
                    write_r = 1'b1;
                end
                OP_MOVF, OP_ADDWF, OP_SUBWF, OP_ANDWF, OP_XORWF, OP_DECFSZ: begin
                    unique case (op)
                        OP_MOVF:  result = src;
                        OP_ADDWF: result = w_q + src;
                        OP_SUBWF: result = src - w_q;
                        OP_ANDWF: result = w_q & src;
                        OP_XORWF: result = w_q ^ src;
                        default:  result = src - DATA_W'(1);
                    endcase
                    write_w = !dest_reg;
                    write_r = dest_reg;
                    upd_z   = 1'b1;
                    // DECFSZ skips the next instruction when the count hits zero.
                    if (op == OP_DECFSZ && result == '0)
                        pc_d = pc_q + PC_W'(2);
                end
                OP_GOTO: pc_d = a;
                OP_BZ:   if (z_q)  pc_d = a;
                OP_BNZ:  if (!z_q) pc_d = a;
                OP_CALL: begin
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        state_d = S_FAULT;
                        pc_d    = pc_q;
                    end else begin
                        stk_push = 1'b1;
                        sp_d     = sp_q + SP_W'(1);
                        pc_d     = a;
                    end
                end
                OP_RETURN: begin
                    if (sp_q == '0) begin
                        state_d = S_FAULT;
                        pc_d    = pc_q;
                    end else begin
                        sp_d = sp_q - SP_W'(1);
                        pc_d = stack[pop_idx];
                    end
                end
                OP_HALT: begin
                    // pc stays on the HALT instruction.
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end
            endcase

            if (write_w) w_d = result;
            if (upd_z)   z_d = (result == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_RUN;
            pc_q    <= '0;
            w_q     <= '0;
            z_q     <= 1'b0;
            sp_q    <= '0;
            // NOTE: the register file and stack are cleared on reset because
            // their contents are architecturally visible and must not survive
            // it; this keeps them out of RAM macros, which is fine at this size.
            for (int i = 0; i < NREGS; i++)       regs[i]  <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            w_q     <= w_d;
            z_q     <= z_d;
            sp_q    <= sp_d;
            if (write_r)  regs[r]         <= result;
            if (stk_push) stack[push_idx] <= pc_inc;
        end
    end

    assign pc       = pc_q;
    assign w        = w_q;
    assign is_zero  = z_q;
    assign halted   = (state_q != S_RUN);
    assign fault    = (state_q == S_FAULT);
    assign dbg_data = regs[dbg_sel];

endmodule

// File: tb/tb_micro_param.sv
// ---------------------------------------------------------------------------
// tb_micro_param
//
// Self-checking bench for micro_param. It drives a default instance
// (8-bit data, 8-bit pc, 4 registers, 4-deep stack) and a wide instance
// (16-bit data, 10-bit pc, 8 registers). Each instance reads from its own
// ROM array. The bench runs directed programs and then random programs.
// The random programs are compared cycle by cycle against an
// instruction-level interpreter of the ISA.
// ---------------------------------------------------------------------------
module tb_micro_param;

    // ---------------- default instance ----------------
    logic        clk;
    logic        reset;
    logic        run;
    logic [12:0] inst;
    logic [7:0]  pc;
    logic [7:0]  w;
    logic        is_zero;
    logic        halted;
    logic        fault;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;
    logic [12:0] rom [256];

    assign inst = rom[pc];

    micro_param dut (
        .clk      (clk),
        .reset    (reset),
        .run      (run),
        .inst     (inst),
        .pc       (pc),
        .w        (w),
        .is_zero  (is_zero),
        .halted   (halted),
        .fault    (fault),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    // ---------------- wide instance ----------------
    logic        wide_reset;
    logic        wide_run;
    logic [20:0] wide_inst;
    logic [9:0]  wide_pc;
    logic [15:0] wide_w;
    logic        wide_zero;
    logic        wide_halted;
    logic        wide_fault;
    logic [2:0]  wide_sel;
    logic [15:0] wide_dbg;
    logic [20:0] wide_rom [1024];

    assign wide_inst = wide_rom[wide_pc];

    micro_param #(.DATA_W(16), .PC_W(10), .NREGS(8), .STACK_DEPTH(4)) dut_wide (
        .clk      (clk),
        .reset    (wide_reset),
        .run      (wide_run),
        .inst     (wide_inst),
        .pc       (wide_pc),
        .w        (wide_w),
        .is_zero  (wide_zero),
        .halted   (wide_halted),
        .fault    (wide_fault),
        .dbg_sel  (wide_sel),
        .dbg_data (wide_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [12:0] mk(input logic [3:0] op, input logic d, input logic [7:0] imm);
        return {op, d, imm};
    endfunction

    function automatic logic [20:0] mkw(input logic [3:0] op, input logic d, input logic [15:0] imm);
        return {op, d, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    // ---------------- reference interpreter (default config) ----------------
    int m_pc, m_w, m_z, m_halt, m_fault;
    int m_regs [4];
    int m_stk  [$];

    task automatic model_step(input bit rst_i, input bit run_i);
        logic [12:0] ins;
        int op, d, imm, r, res, npc;
        bit wr;
        if (!rst_i) begin
            m_pc = 0; m_w = 0; m_z = 0; m_halt = 0; m_fault = 0;
            for (int i = 0; i < 4; i++) m_regs[i] = 0;
            m_stk.delete();
            return;
        end
        if (!run_i || m_halt != 0 || m_fault != 0) return;
        ins = rom[m_pc];
        op  = int'(ins[12:9]);
        d   = int'(ins[8]);
        imm = int'(ins[7:0]);
        r   = imm % 4;
        npc = (m_pc + 1) % 256;
        res = 0;
        wr  = 1'b0;
        case (op)
            1:  begin m_w = imm; m_z = (imm == 0); end
            2:  begin m_w = (m_w + imm) % 256; m_z = (m_w == 0); end
            3:  m_regs[r] = m_w;
            4:  begin res = m_regs[r]; wr = 1'b1; end
            5:  begin res = (m_w + m_regs[r]) % 256; wr = 1'b1; end
            6:  begin res = (m_regs[r] + 256 - m_w) % 256; wr = 1'b1; end
            7:  begin res = m_w & m_regs[r]; wr = 1'b1; end
            8:  begin res = m_w ^ m_regs[r]; wr = 1'b1; end
            9:  npc = imm;
            10: if (m_z != 0) npc = imm;
            11: if (m_z == 0) npc = imm;
            12: begin
                if (m_stk.size() == 4) begin m_fault = 1; npc = m_pc; end
                else begin m_stk.push_back(npc); npc = imm; end
            end
            13: begin
                if (m_stk.size() == 0) begin m_fault = 1; npc = m_pc; end
                else npc = m_stk.pop_back();
            end
            14: begin
                res = (m_regs[r] + 255) % 256;
                wr  = 1'b1;
                if (res == 0) npc = (m_pc + 2) % 256;
            end
            15: begin m_halt = 1; npc = m_pc; end
            default: ;
        endcase
        if (wr) begin
            if (d != 0) m_regs[r] = res;
            else        m_w = res;
            m_z = (res == 0);
        end
        m_pc = npc;
    endtask

    task automatic compare_model(input string tag);
        int sel;
        check({tag, ".pc"},      32'(pc),      32'(m_pc));
        check({tag, ".w"},       32'(w),       32'(m_w));
        check({tag, ".is_zero"}, 32'(is_zero), 32'(m_z));
        check({tag, ".halted"},  32'(halted),  32'((m_halt != 0) || (m_fault != 0)));
        check({tag, ".fault"},   32'(fault),   32'(m_fault));
        sel     = int'($urandom_range(0, 3));
        dbg_sel = 2'(sel);
        #1;
        check({tag, ".dbg"},     32'(dbg_data), 32'(m_regs[sel]));
    endtask

    initial begin
        reset      = 1'b0;
        run        = 1'b1;
        dbg_sel    = '0;
        wide_reset = 1'b0;
        wide_run   = 1'b1;
        wide_sel   = '0;
        clear_rom();
        for (int i = 0; i < 1024; i++) wide_rom[i] = '0;

        // ---- defaults ----
        rom[0] = mk(4'h1, 1'b0, 8'h05);
        rom[1] = mk(4'h2, 1'b0, 8'hFB);
        do_reset();
        check("rst.pc",      32'(pc),      32'h00);
        check("rst.w",       32'(w),       32'h00);
        check("rst.is_zero", 32'(is_zero), 32'h0);
        check("rst.halted",  32'(halted),  32'h0);
        check("rst.fault",   32'(fault),   32'h0);
        tick();
        check("def1.pc", 32'(pc), 32'h01);
        check("def1.w",  32'(w),  32'h05);
        check("def1.z",  32'(is_zero), 32'h0);
        tick();
        check("def2.pc", 32'(pc), 32'h02);
        check("def2.w",  32'(w),  32'h00);
        check("def2.z",  32'(is_zero), 32'h1);

        // ---- countdown loop ----
        clear_rom();
        rom[0] = mk(4'h1, 1'b0, 8'h03);
        rom[1] = mk(4'h3, 1'b0, 8'h01);
        rom[2] = mk(4'hE, 1'b1, 8'h01);
        rom[3] = mk(4'h9, 1'b0, 8'h02);
        rom[4] = mk(4'hF, 1'b0, 8'h00);
        do_reset();
        dbg_sel = 2'd1;
        tick(); tick(); tick();
        check("cnt.r1_first", 32'(dbg_data), 32'h02);
        check("cnt.pc_first", 32'(pc), 32'h03);
        tick(); tick();
        check("cnt.r1_second", 32'(dbg_data), 32'h01);
        tick();
        check("cnt.pc_loop", 32'(pc), 32'h02);
        tick();
        check("cnt.pc_skip", 32'(pc), 32'h04);
        check("cnt.r1_zero", 32'(dbg_data), 32'h00);
        check("cnt.w_kept",  32'(w), 32'h03);
        check("cnt.z",       32'(is_zero), 32'h1);
        tick();
        check("cnt.halted",  32'(halted), 32'h1);
        check("cnt.pc_halt", 32'(pc), 32'h04);
        tick();
        check("cnt.pc_frozen", 32'(pc), 32'h04);
        check("cnt.no_fault",  32'(fault), 32'h0);
        // reset must clear the register file
        do_reset();
        check("cnt.r1_reset", 32'(dbg_data), 32'h00);

        // ---- call / return ----
        clear_rom();
        rom[3]    = mk(4'hC, 1'b0, 8'h10);
        rom[8'h10] = mk(4'hD, 1'b0, 8'h00);
        do_reset();
        tick(); tick(); tick();
        check("call.pc_at", 32'(pc), 32'h03);
        tick();
        check("call.pc_target", 32'(pc), 32'h10);
        tick();
        check("ret.pc", 32'(pc), 32'h04);
        check("ret.no_fault", 32'(fault), 32'h0);

        // ---- stack overflow ----
        clear_rom();
        for (int i = 0; i < 5; i++) rom[i] = mk(4'hC, 1'b0, 8'(i + 1));
        do_reset();
        tick(); tick(); tick(); tick();
        check("ovf.pc_full", 32'(pc), 32'h04);
        check("ovf.full_ok", 32'(fault), 32'h0);
        tick();
        check("ovf.fault",  32'(fault),  32'h1);
        check("ovf.halted", 32'(halted), 32'h1);
        check("ovf.pc",     32'(pc),     32'h04);
        tick();
        check("ovf.pc_frozen", 32'(pc), 32'h04);

        // ---- underflow ----
        clear_rom();
        rom[0] = mk(4'hD, 1'b0, 8'h00);
        do_reset();
        check("unf.fault_clear", 32'(fault), 32'h0);
        tick();
        check("unf.fault",  32'(fault),  32'h1);
        check("unf.halted", 32'(halted), 32'h1);
        check("unf.pc",     32'(pc),     32'h00);

        // ---- branches with is_zero=1 ----
        clear_rom();
        rom[0]    = mk(4'h1, 1'b0, 8'h00);
        rom[1]    = mk(4'hA, 1'b0, 8'h08);
        rom[8]    = mk(4'hB, 1'b0, 8'h20);
        do_reset();
        tick(); tick();
        check("bz.taken", 32'(pc), 32'h08);
        tick();
        check("bnz.fall", 32'(pc), 32'h09);

        // ---- stall and reset while halted ----
        clear_rom();
        rom[0] = mk(4'h1, 1'b0, 8'h01);
        rom[1] = mk(4'h2, 1'b0, 8'h01);
        rom[2] = mk(4'h2, 1'b0, 8'h01);
        rom[3] = mk(4'hF, 1'b0, 8'h00);
        do_reset();
        tick(); tick();
        run = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall.pc", 32'(pc), 32'h02);
            check("stall.w",  32'(w),  32'h02);
        end
        run = 1'b1;
        tick();
        check("resume.pc", 32'(pc), 32'h03);
        check("resume.w",  32'(w),  32'h03);
        tick();
        check("halt.halted", 32'(halted), 32'h1);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("rst_halt.pc",     32'(pc),     32'h00);
        check("rst_halt.halted", 32'(halted), 32'h0);
        check("rst_halt.fault",  32'(fault),  32'h0);
        check("rst_halt.w",      32'(w),      32'h00);

        // ---- wide configuration ----
        wide_rom[0]      = mkw(4'h1, 1'b0, 16'hFFFF);
        wide_rom[1]      = mkw(4'h2, 1'b0, 16'h0001);
        wide_rom[2]      = mkw(4'h9, 1'b0, 16'h03FF);
        wide_rom[10'h3FF] = mkw(4'h0, 1'b0, 16'h0000);
        wide_reset = 1'b0;
        tick();
        wide_reset = 1'b1;
        tick();
        check("wide.w_ffff", 32'(wide_w),    32'hFFFF);
        check("wide.z0",     32'(wide_zero), 32'h0);
        tick();
        check("wide.w_wrap", 32'(wide_w),    32'h0000);
        check("wide.z1",     32'(wide_zero), 32'h1);
        tick();
        check("wide.pc_top", 32'(wide_pc),   32'h3FF);
        tick();
        check("wide.pc_wrap", 32'(wide_pc),  32'h000);
        check("wide.dbg",     32'(wide_dbg), 32'h0000);

        // ---- random programs against the interpreter ----
        for (int p = 0; p < 20; p++) begin
            for (int i = 0; i < 256; i++) begin
                int op;
                op = int'($urandom_range(0, 15));
                if (op == 15 && $urandom_range(0, 3) != 0) op = int'($urandom_range(1, 8));
                rom[i] = mk(4'(op), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
            end
            run = 1'b1;
            model_step(1'b0, 1'b1);
            do_reset();
            compare_model("rnd.reset");
            for (int c = 0; c < 60; c++) begin
                bit rst_i, run_i;
                run_i = ($urandom_range(0, 9) != 0);
                rst_i = ($urandom_range(0, 49) != 0);
                run   = run_i;
                reset = rst_i;
                model_step(rst_i, run_i);
                tick();
                reset = 1'b1;
                compare_model("rnd.step");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
